// File: rtl/truth_table_scanner_pkg.sv
// Shared types and helpers for the truth-table scanner (package tt_scan_pkg).
package tt_scan_pkg;

    localparam int N_IN_DEF = 4;
    localparam int ROWS     = 2**N_IN_DEF;
    localparam int CNT_W    = N_IN_DEF + 1;
    localparam int MAX_ROWS = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Lowest-numbered set bit wins; returns 0 for an all-zero vector.
    function automatic logic [5:0] lowest_set_idx(input logic [MAX_ROWS-1:0] vec);
        logic [5:0] idx;
        idx = '0;
        for (int i = MAX_ROWS - 1; i >= 0; i--) begin
            if (vec[i]) idx = 6'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/truth_table_scanner_emitter.sv
// Maxterm index emitter: holds a work copy of the mask and streams set-bit indices
// in ascending order over a valid/ready interface.
module tt_index_emitter
    import tt_scan_pkg::*;
#(
    parameter int N_IN = N_IN_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic [2**N_IN-1:0]   i_mask,
    input  logic                 i_en,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic [N_IN-1:0]      o_data,
    output logic                 o_last
);
    localparam int R = 2**N_IN;

    logic [R-1:0]        r_work;
    logic [MAX_ROWS-1:0] w_ext;
    logic [5:0]          w_idx;
    logic [R-1:0]        w_clear;
    logic                w_hs;

    assign w_ext   = MAX_ROWS'(r_work);
    assign w_idx   = lowest_set_idx(w_ext);
    assign w_clear = R'(1) << w_idx;

    // Valid/ready: a transfer happens on any rising edge where o_valid and i_ready
    // are both high; o_valid/o_data only change after a transfer, so they hold under stall.
    assign o_valid = i_en && (|r_work);
    assign o_data  = o_valid ? N_IN'(w_idx) : '0;
    assign w_hs    = o_valid && i_ready;
    assign o_last  = w_hs && ((r_work & ~w_clear) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= '0;
        end else if (i_load) begin
            r_work <= i_mask;
        end else if (w_hs) begin
            r_work <= r_work & ~w_clear;
        end
    end

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps all input rows of an external function and recovers its maxterms.
// Define TT_SETTLE_EN to spend two cycles per row (drive, then sample).
module truth_table_scanner
    import tt_scan_pkg::*;
#(
    parameter int N_IN = N_IN_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [N_IN-1:0]      stim,
    input  logic                 f_in,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   maxterm_mask,
    output logic [N_IN:0]        maxterm_cnt,
    output logic                 idx_valid,
    input  logic                 idx_ready,
    output logic [N_IN-1:0]      idx_data,
    output logic [1:0]           dbg_state
);
    localparam int R = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_ROW = N_IN'(R - 1);

    state_t          r_state;
    state_t          w_next;
    logic [N_IN-1:0] r_stim;
    logic [R-1:0]    r_mask;
    logic [N_IN:0]   r_cnt;
    logic            w_sample;
    logic            w_last_row;
    logic [R-1:0]    w_mask_next;
    logic [N_IN:0]   w_cnt_next;
    logic            w_emit_last;

`ifdef TT_SETTLE_EN
    logic r_phase;

    // Phase 0 drives the row, phase 1 samples it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= 1'b0;
        end else if (r_state != SWEEP) begin
            r_phase <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
        end
    end

    assign w_sample = (r_state == SWEEP) && r_phase;
`else
    assign w_sample = (r_state == SWEEP);
`endif

    assign w_last_row = (r_stim == LAST_ROW);

    always_comb begin
        w_mask_next         = r_mask;
        w_mask_next[r_stim] = ~f_in;
        w_cnt_next          = r_cnt + {{N_IN{1'b0}}, ~f_in};
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SWEEP;
            SWEEP:   if (w_sample && w_last_row) w_next = (w_cnt_next != '0) ? EMIT : DONE;
            EMIT:    if (w_emit_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Row counter wraps back to 0 after the last row on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stim <= '0;
            r_mask <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_stim <= '0;
                        r_mask <= '0;
                        r_cnt  <= '0;
                    end
                end
                SWEEP: begin
                    if (w_sample) begin
                        r_mask <= w_mask_next;
                        r_cnt  <= w_cnt_next;
                        r_stim <= r_stim + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    tt_index_emitter #(.N_IN(N_IN)) u_emitter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_sample && w_last_row),
        .i_mask  (w_mask_next),
        .i_en    (r_state == EMIT),
        .i_ready (idx_ready),
        .o_valid (idx_valid),
        .o_data  (idx_data),
        .o_last  (w_emit_last)
    );

    assign stim         = r_stim;
    assign busy         = (r_state == SWEEP) || (r_state == EMIT);
    assign done         = (r_state == DONE);
    assign maxterm_mask = r_mask;
    assign maxterm_cnt  = r_cnt;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner with a queue-based stream scoreboard.
module tb_truth_table_scanner;

`ifdef TT_SETTLE_EN
    localparam int RC = 2;
`else
    localparam int RC = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  stim;
    logic        f_in;
    logic        busy;
    logic        done;
    logic [15:0] mask;
    logic [4:0]  cnt;
    logic        idx_valid;
    logic        idx_ready;
    logic [3:0]  idx_data;
    logic [1:0]  dbg_state;
    logic [15:0] f_tbl;

    logic        start3;
    logic [2:0]  stim3;
    logic        f3;
    logic        busy3;
    logic        done3;
    logic [7:0]  mask3;
    logic [3:0]  cnt3;
    logic        valid3;
    logic        ready3;
    logic [2:0]  data3;
    logic [1:0]  state3;
    logic [7:0]  f3_tbl;

    assign f_in = f_tbl[stim];
    assign f3   = f3_tbl[stim3];

    truth_table_scanner #(.N_IN(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .f_in(f_in),
        .busy(busy), .done(done), .maxterm_mask(mask), .maxterm_cnt(cnt),
        .idx_valid(idx_valid), .idx_ready(idx_ready), .idx_data(idx_data),
        .dbg_state(dbg_state)
    );

    truth_table_scanner #(.N_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .stim(stim3), .f_in(f3),
        .busy(busy3), .done(done3), .maxterm_mask(mask3), .maxterm_cnt(cnt3),
        .idx_valid(valid3), .idx_ready(ready3), .idx_data(data3),
        .dbg_state(state3)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard / monitors
    logic [3:0] exp_q[$];
    logic [2:0] exp3_q[$];
    int         done_pulses = 0;
    logic       prev_stall  = 1'b0;
    logic [3:0] prev_data   = '0;
    logic       prev_done   = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_stall) begin
                    check("hold_valid", 32'(idx_valid), 32'd1);
                    check("hold_data", 32'(idx_data), 32'(prev_data));
                end
                if (idx_valid && idx_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL stream_extra: got idx %0d expected none", idx_data);
                    end else begin
                        check("stream_idx", 32'(idx_data), 32'(exp_q.pop_front()));
                    end
                end
                if (done) begin
                    done_pulses++;
                    if (prev_done) begin
                        total++;
                        bad++;
                        $display("FAIL done_width: got done high 2 cycles expected 1");
                    end
                end
                prev_stall = idx_valid && !idx_ready;
                prev_data  = idx_data;
                prev_done  = done;
            end else begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && valid3 && ready3) begin
                if (exp3_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stream3_extra: got idx %0d expected none", data3);
                end else begin
                    check("stream3_idx", 32'(data3), 32'(exp3_q.pop_front()));
                end
            end
        end
    end

    // driver tasks
    task automatic push_m7();
        exp_q.push_back(4'd1); exp_q.push_back(4'd2); exp_q.push_back(4'd4);
        exp_q.push_back(4'd7); exp_q.push_back(4'd8); exp_q.push_back(4'd9);
        exp_q.push_back(4'd15);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_scan(input string tag, input int exp_done_iter, input logic [15:0] exp_mask,
                            input int exp_cnt, input bit do_stall, input bit poke_start);
        int iter;
        int first_valid = -1;
        int valid_cycles = 0;
        int stim_err = 0;
        int done_iter = -1;
        int stall_left = 0;
        int dp0;
        bit stalled = 0;
        bit poked = 0;
        dp0 = done_pulses;
        idx_ready = 1'b1;
        pulse_start();
        iter = 0;
        while (done_iter < 0 && iter < 300) begin
            @(posedge clk); #1;
            iter++;
            if (iter < 16*RC && stim !== 4'(iter/RC)) stim_err++;
            if (idx_valid) begin
                valid_cycles++;
                if (first_valid < 0) first_valid = iter;
            end
            if (done) done_iter = iter;
            if (do_stall && !stalled && idx_valid && idx_data == 4'd4) begin
                stalled = 1;
                stall_left = 3;
            end
            idx_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (poke_start && !poked && idx_valid) begin
                start = 1'b1;
                poked = 1;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, "_done_iter"}, 32'(done_iter), 32'(exp_done_iter));
        check({tag, "_stim_seq"}, 32'(stim_err), 32'd0);
        check({tag, "_first_valid"}, 32'(first_valid), (exp_cnt > 0) ? 32'(16*RC) : 32'hFFFF_FFFF);
        check({tag, "_valid_cycles"}, 32'(valid_cycles), 32'(exp_cnt + (do_stall ? 3 : 0)));
        check({tag, "_mask"}, 32'(mask), 32'(exp_mask));
        check({tag, "_cnt"}, 32'(cnt), 32'(exp_cnt));
        idx_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_done_fall"}, 32'(done), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_state_idle"}, 32'(dbg_state), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check({tag, "_done_count"}, 32'(done_pulses - dp0), 32'd1);
        check({tag, "_mask_hold"}, 32'(mask), 32'(exp_mask));
        check({tag, "_cnt_hold"}, 32'(cnt), 32'(exp_cnt));
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int iter;
        int dp0;
        rst_n     = 1'b0;
        start     = 1'b0;
        idx_ready = 1'b1;
        f_tbl     = 16'hFFFF;
        start3    = 1'b0;
        ready3    = 1'b1;
        f3_tbl    = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_stim", 32'(stim), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mask", 32'(mask), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_valid", 32'(idx_valid), 32'd0);
        check("rst_data", 32'(idx_data), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;

        // f = PoS M(1,2,4,7,8,9,15)
        f_tbl = 16'h7C69;
        push_m7();
        run_scan("m7", 16*RC + 7, 16'h8396, 7, 0, 0);

        f_tbl = 16'hFFFF;
        run_scan("ones", 16*RC, 16'h0000, 0, 0, 0);

        f_tbl = 16'h0000;
        for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
        run_scan("zeros", 16*RC + 16, 16'hFFFF, 16, 0, 0);

        f_tbl = 16'h7C69;
        push_m7();
        run_scan("bp", 16*RC + 10, 16'h8396, 7, 1, 0);

        push_m7();
        run_scan("poke", 16*RC + 7, 16'h8396, 7, 0, 1);

        // abort mid-sweep at row 5
        dp0 = done_pulses;
        pulse_start();
        iter = 0;
        while (stim != 4'd5 && iter < 100) begin
            @(posedge clk); #1;
            iter++;
        end
        check("abort_reach_row5", 32'(stim), 32'd5);
        rst_n = 1'b0;
        #1;
        check("abort_stim", 32'(stim), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mask", 32'(mask), 32'd0);
        check("abort_cnt", 32'(cnt), 32'd0);
        check("abort_valid", 32'(idx_valid), 32'd0);
        check("abort_state", 32'(dbg_state), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_pulses - dp0), 32'd0);
        push_m7();
        run_scan("rerun", 16*RC + 7, 16'h8396, 7, 0, 0);

        // N_IN=3, f = PoS M(1,2,6,7)
        f3_tbl = 8'h39;
        exp3_q.push_back(3'd1); exp3_q.push_back(3'd2);
        exp3_q.push_back(3'd6); exp3_q.push_back(3'd7);
        @(posedge clk); #1 start3 = 1'b1;
        @(posedge clk); #1 start3 = 1'b0;
        iter = 0;
        while (!done3 && iter < 200) begin
            @(posedge clk); #1;
            iter++;
        end
        check("n3_done_iter", 32'(iter), 32'(8*RC + 4));
        check("n3_mask", 32'(mask3), 32'h00C6);
        check("n3_cnt", 32'(cnt3), 32'd4);
        @(posedge clk); #1;
        check("n3_queue_empty", 32'(exp3_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
